// File: rtl/ddram_clear_check_if.sv
// ddram_clear_check_if: read side of the DDRAM burst interface plus the tied-off write side.
// master = the verifier (issues requests, consumes beats); slave = the memory controller.
// Signals keep the controller's native names so the wiring matches the rest of the core.
interface ddram_clear_check_if;
   logic        DDRAM_BUSY;
   logic [7:0]  DDRAM_BURSTCNT;
   logic [28:0] DDRAM_ADDR;
   logic        DDRAM_RD;
   logic [63:0] DDRAM_DOUT;
   logic        DDRAM_DOUT_READY;
   logic        DDRAM_WE;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE;

   modport master (
      input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
      output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
   );

   modport slave (
      output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
      input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
   );
endinterface

// File: rtl/ddram_clear_check.sv
// ddram_clear_check: sweeps WORDS 64-bit words from BASE with burst reads, checks each beat against PATTERN.
// Latency: start -> RD/active next cycle; done the cycle after the last beat; one request cycle per burst.
// Backpressure: request held stable while DDRAM_BUSY; one burst outstanding; beats only counted on DOUT_READY.
// Ports: clk_sys/reset_n; start in; active/done/pass status; err_addr/err_data first mismatch, err_count
// saturating mismatch count; ddram = read master on the DDRAM interface (write side tied off).
module ddram_clear_check #(
   parameter logic [28:0] BASE    = 29'h0000000,
   parameter logic [28:0] WORDS   = 29'h0100000,
   parameter int unsigned BURST   = 128,
   parameter logic [63:0] PATTERN = 64'h0
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                start,
   output logic                active,
   output logic                done,
   output logic                pass,
   output logic [28:0]         err_addr,
   output logic [63:0]         err_data,
   output logic [15:0]         err_count,
   ddram_clear_check_if.master ddram
);
   typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

   localparam logic [29:0] BURST_W = 30'(BURST);

   state_t      state, state_nxt;
   logic [28:0] cur;
   logic [29:0] remaining;
   logic [7:0]  beat_idx;
   logic [7:0]  burst_len;
   logic        accept;
   logic        beat;
   logic        last_beat;
   logic        mismatch;
   logic        launch;

   // remaining only changes on the last beat of a burst, so this length is stable
   // for the whole REQ/DATA pair and reads 0 out of reset and in DONE.
   assign burst_len = (remaining < BURST_W) ? remaining[7:0] : BURST_W[7:0];
   assign launch    = ((state == IDLE) || (state == DONE)) && start;
   assign accept    = (state == REQ) && !ddram.DDRAM_BUSY;
   assign beat      = (state == DATA) && ddram.DDRAM_DOUT_READY;
   assign last_beat = beat && (beat_idx == burst_len - 8'd1);
   assign mismatch  = beat && (ddram.DDRAM_DOUT != PATTERN);

   assign ddram.DDRAM_RD       = (state == REQ);
   assign ddram.DDRAM_ADDR     = cur;
   assign ddram.DDRAM_BURSTCNT = burst_len;
   assign ddram.DDRAM_WE       = 1'b0;
   assign ddram.DDRAM_DIN      = 64'h0;
   assign ddram.DDRAM_BE       = 8'hFF;

   assign active = (state == REQ) || (state == DATA);
   assign done   = (state == DONE);
   assign pass   = done && (err_count == 16'h0);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = REQ;
         REQ:        if (accept) state_nxt = DATA;
         DATA: begin
            // remaining still holds the pre-burst count on the final beat
            if (last_beat) state_nxt = (remaining == {22'd0, burst_len}) ? DONE : REQ;
         end
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cur       <= '0;
         remaining <= '0;
         beat_idx  <= '0;
         err_addr  <= '0;
         err_data  <= '0;
         err_count <= '0;
      end else begin
         if (launch) begin
            cur       <= BASE;
            remaining <= {1'b0, WORDS};
            err_addr  <= '0;
            err_data  <= '0;
            err_count <= '0;
         end
         if (accept) beat_idx <= '0;
         if (beat) begin
            beat_idx <= beat_idx + 8'd1;
            if (mismatch) begin
               // only the first mismatch of a sweep is recorded
               if (err_count == 16'h0) begin
                  err_addr <= cur + 29'(beat_idx);
                  err_data <= ddram.DDRAM_DOUT;
               end
               if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            if (last_beat) begin
               cur       <= cur + 29'(burst_len);
               remaining <= remaining - 30'(burst_len);
            end
         end
      end
   end
endmodule

// File: tb/tb_ddram_clear_check.sv
// Bench: three verifier instances (main 300-word range, top-of-memory wrap range, saturation range),
// each served by a burst-read memory responder with programmable BUSY stalls and data gaps.
// Expected results come from hand tables and from a word-by-word reference model of the sweep.
module tb_ddram_clear_check;
   typedef struct {
      int          g;
      logic [28:0] addr;
      logic [7:0]  cnt;
   } req_t;

   typedef struct {
      int          fa0, fa1, fa2;
      logic [63:0] fd;
      int          busy;
      int          ecnt;
      logic [28:0] eaddr;
      logic [63:0] edata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  start = 3'b000;
   logic [2:0]  active, done, pass;
   logic [28:0] err_addr [3];
   logic [63:0] err_data [3];
   logic [15:0] err_count [3];
   logic [2:0]  rd_mon, tie_ok;
   logic [28:0] addr_mon [3];
   logic [7:0]  bcnt_mon [3];

   int          busy_cfg [3];
   bit          gap_en [3];
   int          stab_err [3];
   int          pend [3];
   req_t        log_q [$];
   req_t        exp_bursts [$];
   logic [63:0] faults [logic [31:0]];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [63:0] word_data(input int g, input logic [28:0] a);
      logic [31:0] key;
      key = {g[2:0], a};
      if (g == 2) return 64'hA5A5_0000_0000_0000 | {35'd0, a};
      if (faults.exists(key)) return faults[key];
      return 64'h0;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : inst
      ddram_clear_check_if bus ();

      ddram_clear_check #(
         .BASE   (g == 1 ? 29'h1FFFFFF0 : 29'h0),
         .WORDS  (g == 0 ? 29'd300 : (g == 1 ? 29'd32 : 29'd65540)),
         .BURST  (g == 0 ? 128 : (g == 1 ? 16 : 255)),
         .PATTERN(64'h0)
      ) dut (
         .clk_sys  (clk),
         .reset_n  (rst_n),
         .start    (start[g]),
         .active   (active[g]),
         .done     (done[g]),
         .pass     (pass[g]),
         .err_addr (err_addr[g]),
         .err_data (err_data[g]),
         .err_count(err_count[g]),
         .ddram    (bus)
      );

      assign rd_mon[g]   = bus.DDRAM_RD;
      assign addr_mon[g] = bus.DDRAM_ADDR;
      assign bcnt_mon[g] = bus.DDRAM_BURSTCNT;
      assign tie_ok[g]   = (bus.DDRAM_WE == 1'b0) && (bus.DDRAM_DIN == 64'h0) && (bus.DDRAM_BE == 8'hFF);

      // Memory responder: everything driven at negedge. A request seen with BUSY low
      // here is accepted at the next posedge, and its beats start the negedge after.
      initial begin : resp
         logic [28:0] beatq [$];
         int          busy_left;
         bit          in_req;
         logic [28:0] req_addr;
         logic [7:0]  req_cnt;
         busy_left = 0;
         in_req    = 1'b0;
         req_addr  = '0;
         req_cnt   = '0;
         bus.DDRAM_BUSY       = 1'b0;
         bus.DDRAM_DOUT       = 64'h0;
         bus.DDRAM_DOUT_READY = 1'b0;
         forever begin
            @(negedge clk);
            if (beatq.size() > 0 && (!gap_en[g] || $urandom_range(0, 1) == 1)) begin
               bus.DDRAM_DOUT_READY = 1'b1;
               bus.DDRAM_DOUT       = word_data(g, beatq.pop_front());
            end else begin
               bus.DDRAM_DOUT_READY = 1'b0;
               bus.DDRAM_DOUT       = gap_en[g] ? {$urandom, $urandom} : 64'h0;
            end
            if (bus.DDRAM_RD) begin
               if (!in_req) begin
                  in_req    = 1'b1;
                  req_addr  = bus.DDRAM_ADDR;
                  req_cnt   = bus.DDRAM_BURSTCNT;
                  busy_left = (busy_cfg[g] < 0) ? int'($urandom_range(0, 3)) : busy_cfg[g];
               end else if (bus.DDRAM_ADDR != req_addr || bus.DDRAM_BURSTCNT != req_cnt) begin
                  stab_err[g]++;
               end
               if (busy_left > 0) begin
                  bus.DDRAM_BUSY = 1'b1;
                  busy_left--;
               end else begin
                  bus.DDRAM_BUSY = 1'b0;
                  in_req = 1'b0;
                  for (int i = 0; i < int'(req_cnt); i++) beatq.push_back(req_addr + 29'(i));
                  log_q.push_back('{g, req_addr, req_cnt});
               end
            end else begin
               in_req = 1'b0;
               bus.DDRAM_BUSY = gap_en[g] ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            pend[g] = beatq.size();
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: walk every word of the range, then split the range into bursts.
   task automatic model(input int g, input logic [28:0] base, input int words, input int burst,
                        output int cnt, output logic [28:0] fa, output logic [63:0] fd);
      logic [28:0] a;
      logic [63:0] d;
      int          rem, n;
      cnt = 0; fa = '0; fd = '0;
      for (int i = 0; i < words; i++) begin
         a = base + 29'(i);
         d = word_data(g, a);
         if (d != 64'h0) begin
            if (cnt == 0) begin fa = a; fd = d; end
            if (cnt < 65535) cnt++;
         end
      end
      exp_bursts.delete();
      a = base; rem = words;
      while (rem > 0) begin
         n = (rem < burst) ? rem : burst;
         exp_bursts.push_back('{g, a, 8'(n)});
         a = a + 29'(n);
         rem -= n;
      end
   endtask

   task automatic run_sweep(input int g, input int budget, output int cycles);
      int n;
      log_q.delete();
      @(negedge clk); start[g] = 1'b1;
      @(negedge clk); start[g] = 1'b0;
      check($sformatf("i%0d start active", g), active[g], 1);
      check($sformatf("i%0d start rd", g), rd_mon[g], 1);
      check($sformatf("i%0d start done clear", g), done[g], 0);
      n = 0;
      while (!done[g] && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("i%0d sweep finished in budget", g), done[g], 1);
      cycles = n;
   endtask

   task automatic check_result(input int g, input string tag, input int ecnt,
                               input logic [28:0] ea, input logic [63:0] ed);
      check({tag, " done"}, done[g], 1);
      check({tag, " active"}, active[g], 0);
      check({tag, " pass"}, pass[g], (ecnt == 0) ? 1 : 0);
      check({tag, " err_count"}, err_count[g], 64'(ecnt));
      check({tag, " err_addr"}, err_addr[g], ea);
      check({tag, " err_data"}, err_data[g], ed);
   endtask

   task automatic check_bursts(input int g, input string tag);
      req_t got [$];
      foreach (log_q[i]) if (log_q[i].g == g) got.push_back(log_q[i]);
      check({tag, " burst count"}, got.size(), exp_bursts.size());
      for (int i = 0; i < exp_bursts.size() && i < got.size(); i++) begin
         check($sformatf("%s burst%0d addr", tag, i), got[i].addr, exp_bursts[i].addr);
         check($sformatf("%s burst%0d len", tag, i), got[i].cnt, exp_bursts[i].cnt);
      end
   endtask

   task automatic drain(input int g);
      int n = 0;
      while (pend[g] != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("i%0d stray beats drained", g), (pend[g] == 0) ? 1 : 0, 1);
      repeat (64) @(negedge clk);
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      vec_t        vt [6];
      int          cyc, ecnt, nf, stab0;
      logic [28:0] ea;
      logic [63:0] ed;

      vt[0] = '{-1, -1, -1, 64'h0, 0, 0, 29'd0, 64'h0};
      vt[1] = '{200, -1, -1, 64'hDEAD_BEEF, 0, 1, 29'd200, 64'hDEAD_BEEF};
      vt[2] = '{5, 6, 299, 64'h0000_0001_0000_0000, 0, 3, 29'd5, 64'h0000_0001_0000_0000};
      vt[3] = '{-1, -1, -1, 64'h0, 7, 0, 29'd0, 64'h0};
      vt[4] = '{0, 128, 255, 64'h8000_0000_0000_0000, 3, 3, 29'd0, 64'h8000_0000_0000_0000};
      vt[5] = '{127, 300, -1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 29'd127, 64'hFFFF_FFFF_FFFF_FFFF};

      for (int g = 0; g < 3; g++) begin busy_cfg[g] = 0; gap_en[g] = 1'b0; stab_err[g] = 0; end

      // reset state
      repeat (3) @(negedge clk);
      check("reset active", active[0], 0);
      check("reset done", done[0], 0);
      check("reset pass", pass[0], 0);
      check("reset err_count", err_count[0], 0);
      check("reset err_addr", err_addr[0], 0);
      check("reset err_data", err_data[0], 0);
      check("reset rd", rd_mon[0], 0);
      check("reset addr", addr_mon[0], 0);
      check("reset burstcnt", bcnt_mon[0], 0);
      check("write side tied off", tie_ok, 3'b111);
      rst_n = 1'b1;
      repeat (64) @(negedge clk);

      // directed table on the 300-word / 128-beat instance
      for (int v = 0; v < 6; v++) begin
         faults.delete();
         if (vt[v].fa0 >= 0) faults[{3'd0, 29'(vt[v].fa0)}] = vt[v].fd;
         if (vt[v].fa1 >= 0) faults[{3'd0, 29'(vt[v].fa1)}] = vt[v].fd;
         if (vt[v].fa2 >= 0) faults[{3'd0, 29'(vt[v].fa2)}] = vt[v].fd;
         busy_cfg[0] = vt[v].busy;
         model(0, 29'd0, 300, 128, ecnt, ea, ed);
         stab0 = stab_err[0];
         run_sweep(0, 2000, cyc);
         check_result(0, $sformatf("vec%0d", v), vt[v].ecnt, vt[v].eaddr, vt[v].edata);
         check_bursts(0, $sformatf("vec%0d", v));
         // 300 beats plus one request cycle and the BUSY stall per burst
         check($sformatf("vec%0d cycles", v), cyc, 303 + 3 * vt[v].busy);
         check($sformatf("vec%0d request stable under busy", v), stab_err[0] - stab0, 0);
      end
      check("bursts of clean sweep", exp_bursts.size(), 3);

      // randomized faults, BUSY stalls and beat gaps against the reference model
      for (int r = 0; r < 6; r++) begin
         faults.delete();
         nf = int'($urandom_range(0, 4));
         for (int k = 0; k < nf; k++)
            faults[{3'd0, 29'($urandom_range(0, 320))}] = {$urandom, $urandom} | 64'h1;
         busy_cfg[0] = -1;
         gap_en[0]   = 1'b1;
         model(0, 29'd0, 300, 128, ecnt, ea, ed);
         stab0 = stab_err[0];
         run_sweep(0, 4000, cyc);
         check_result(0, $sformatf("rnd%0d", r), ecnt, ea, ed);
         check_bursts(0, $sformatf("rnd%0d", r));
         check($sformatf("rnd%0d request stable", r), stab_err[0] - stab0, 0);
      end
      busy_cfg[0] = 0;
      gap_en[0]   = 1'b0;

      // reset during the second burst; the rest of that burst arrives in IDLE
      faults.delete();
      for (int a = 140; a < 160; a++) faults[{3'd0, 29'(a)}] = 64'h5;
      log_q.delete();
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      cyc = 0;
      while (log_q.size() < 2 && cyc < 1000) begin @(negedge clk); cyc++; end
      check("second burst reached", (log_q.size() >= 2) ? 1 : 0, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset active", active[0], 0);
      check("midreset done", done[0], 0);
      check("midreset rd", rd_mon[0], 0);
      check("midreset addr", addr_mon[0], 0);
      check("midreset burstcnt", bcnt_mon[0], 0);
      check("midreset err_count", err_count[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      drain(0);
      check("stray beats err_count", err_count[0], 0);
      check("stray beats done", done[0], 0);
      check("stray beats active", active[0], 0);
      check("no request after reset", log_q.size(), 2);

      // wrap past the top of the address space
      faults.delete();
      faults[{3'd1, 29'h1FFFFFFF}] = 64'h77;
      faults[{3'd1, 29'h0000003}]  = 64'h88;
      busy_cfg[1] = 2;
      gap_en[1]   = 1'b1;
      model(1, 29'h1FFFFFF0, 32, 16, ecnt, ea, ed);
      run_sweep(1, 1000, cyc);
      check_result(1, "wrap", 2, 29'h1FFFFFFF, 64'h77);
      check_bursts(1, "wrap");
      check("wrap first addr", (log_q.size() > 0) ? log_q[0].addr : 29'h1234567, 29'h1FFFFFF0);
      check("wrap second addr", (log_q.size() > 1) ? log_q[1].addr : 29'h1234567, 29'h0);

      // every word mismatches: count saturates, then a restart clears the results
      model(2, 29'd0, 65540, 255, ecnt, ea, ed);
      run_sweep(2, 70000, cyc);
      check_result(2, "sat", 65535, 29'd0, 64'hA5A5_0000_0000_0000);
      check_bursts(2, "sat");
      @(negedge clk); start[2] = 1'b1;
      @(negedge clk); start[2] = 1'b0;
      check("restart err_count", err_count[2], 0);
      check("restart done", done[2], 0);
      check("restart pass", pass[2], 0);
      check("restart active", active[2], 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drain(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
